// File: rtl/huff_byte_packer.sv
// huff_byte_packer: packs {len,code} FIFO words MSB-first into a byte stream.
// Define HUFF_PACK_STATS_EN to add the bits_total/bytes_total counters.
module huff_byte_packer #(
   parameter int ACC_W = 40
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fifo_data,
   input  logic        fifo_empty,
   output logic        fifo_rd,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        flush_done,
   output logic        len_err
`ifdef HUFF_PACK_STATS_EN
   ,
   output logic [31:0] bits_total,
   output logic [31:0] bytes_total
`endif
);

   localparam int CW = $clog2(ACC_W + 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e           st_q, st_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             len_err_q, len_err_d;
   logic             fd_q, fd_d;

   logic [4:0]       len;
   logic [26:0]      mask;
   logic [ACC_W-1:0] code_ext;
   logic [CW-1:0]    shamt;
   logic             hs;
   logic             pop;

   assign len = fifo_data[31:27];
   // 27-bit wrap makes len=27 yield an all-ones mask
   assign mask     = (27'd1 << len) - 27'd1;
   assign code_ext = ACC_W'(fifo_data[26:0] & mask);
   assign shamt    = CW'(ACC_W) - cnt_q - CW'(len);

   assign byte_valid = (cnt_q >= CW'(8));
   assign byte_out   = acc_q[ACC_W-1 -: 8];
   assign hs         = byte_valid & byte_ready;
   assign pop        = rst_n & ~fifo_empty & ~byte_valid & (st_q == RUN);
   assign fifo_rd    = pop;
   assign flush_done = fd_q;
   assign len_err    = len_err_q;

   // next state: byte drain, code append, flush entry/exit
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      st_d      = st_q;
      len_err_d = len_err_q;
      fd_d      = 1'b0;
      if (hs) begin
         acc_d = acc_q << 8;
         cnt_d = cnt_q - CW'(8);
      end
      if (pop) begin
         if (len == 5'd0) begin
            st_d = FLUSH;
            if (cnt_q != CW'(0))
               cnt_d = CW'(8);
         end else if (len > 5'd27) begin
            len_err_d = 1'b1;
         end else begin
            acc_d = acc_q | (code_ext << shamt);
            cnt_d = cnt_q + CW'(len);
         end
      end
      unique case (st_q)
         RUN: ;
         FLUSH: begin
            if (cnt_q == CW'(0) || (cnt_q == CW'(8) && hs)) begin
               st_d = RUN;
               fd_d = 1'b1;
            end
         end
         default: st_d = RUN;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         st_q      <= RUN;
         len_err_q <= 1'b0;
         fd_q      <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         st_q      <= st_d;
         len_err_q <= len_err_d;
         fd_q      <= fd_d;
      end
   end

`ifdef HUFF_PACK_STATS_EN
   logic [31:0] bits_q;
   logic [31:0] bytes_q;
   logic        take;

   assign take        = pop & (len != 5'd0) & (len <= 5'd27);
   assign bits_total  = bits_q;
   assign bytes_total = bytes_q;

   // accepted code bits and byte handshakes, wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bits_q  <= '0;
         bytes_q <= '0;
      end else begin
         if (take)
            bits_q <= bits_q + 32'(len);
         if (hs)
            bytes_q <= bytes_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_huff_byte_packer.sv
// tb_huff_byte_packer: directed and random checks of huff_byte_packer
// against a bit-queue reference model.
`timescale 1ns/1ps
module tb_huff_byte_packer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] fifo_data = 32'h0;
   logic        fifo_empty = 1'b1;
   logic        fifo_rd;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        byte_ready = 1'b0;
   logic        flush_done;
   logic        len_err;
`ifdef HUFF_PACK_STATS_EN
   logic [31:0] bits_total;
   logic [31:0] bytes_total;
`endif

   int nvec = 0;
   int nerr = 0;

   huff_byte_packer #(.ACC_W(40)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .fifo_rd    (fifo_rd),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .flush_done (flush_done),
      .len_err    (len_err)
`ifdef HUFF_PACK_STATS_EN
      ,
      .bits_total (bits_total),
      .bytes_total(bytes_total)
`endif
   );

   always #5 clk = ~clk;

   // FIFO model
   logic [31:0] fq[$];
   logic        p_rd;
   int          cyc = 0;

   function automatic void fifo_refresh();
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
   endfunction

   // pop the head at the edge where fifo_rd was high
   always @(posedge clk) begin
      p_rd = fifo_rd;
      cyc++;
      #1;
      if (p_rd && fq.size() != 0)
         void'(fq.pop_front());
      fifo_refresh();
   end

   // monitor, sampled 1ns before each rising edge
   logic [7:0] got[$];
   int         hs_cyc[$];
   int         fd_cyc[$];
   int         fl_pop_cyc[$];

   always @(negedge clk) begin
      #4;
      if (rst_n) begin
         if (byte_valid && byte_ready) begin
            got.push_back(byte_out);
            hs_cyc.push_back(cyc);
         end
         if (flush_done)
            fd_cyc.push_back(cyc);
         if (fifo_rd && fifo_data[31:27] == 5'd0)
            fl_pop_cyc.push_back(cyc);
      end
   end

   // reference model: words since reset -> expected bytes
   logic [31:0] words[$];
   logic [7:0]  exp_b[$];
   int          exp_fl;
   bit          exp_err;
   int          exp_bits;

   function automatic void model();
      bit bits[$];
      exp_b.delete();
      exp_fl   = 0;
      exp_err  = 0;
      exp_bits = 0;
      foreach (words[i]) begin
         int L = int'(words[i][31:27]);
         if (L == 0) begin
            while (bits.size() % 8 != 0)
               bits.push_back(1'b0);
            exp_fl++;
         end else if (L > 27) begin
            exp_err = 1;
         end else begin
            for (int b = L - 1; b >= 0; b--)
               bits.push_back(words[i][b]);
            exp_bits += L;
         end
         while (bits.size() >= 8) begin
            logic [7:0] v;
            for (int b = 0; b < 8; b++)
               v[7-b] = bits.pop_front();
            exp_b.push_back(v);
         end
      end
   endfunction

   function automatic logic [31:0] w(input int L, input logic [26:0] c);
      return {5'(L), c};
   endfunction

   function automatic void clear_logs();
      got.delete();
      hs_cyc.delete();
      fd_cyc.delete();
      fl_pop_cyc.delete();
      words.delete();
   endfunction

   task automatic push(input logic [31:0] x);
      words.push_back(x);
      fq.push_back(x);
      fifo_refresh();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      byte_ready = 1'b0;
      fq.delete();
      fifo_refresh();
      repeat (2) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
   endtask

   task automatic drain(input bit rnd, input string nm);
      int quiet = 0;
      int n = 0;
      while (quiet < 4 && n < 2000) begin
         @(negedge clk);
         n++;
         byte_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         #2;
         if (fq.size() == 0 && !byte_valid)
            quiet++;
         else
            quiet = 0;
      end
      nvec++;
      if (quiet < 4) begin
         nerr++;
         $display("FAIL %s drain_timeout: quiet=%0d required 4", nm, quiet);
      end
   endtask

   task automatic check_stream(input string nm);
      model();
      nvec++;
      if (got.size() != exp_b.size()) begin
         nerr++;
         $display("FAIL %s byte_count: got %0d required %0d", nm, got.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < got.size(); i++) begin
         nvec++;
         if (got[i] !== exp_b[i]) begin
            nerr++;
            $display("FAIL %s byte[%0d]: got %h required %h", nm, i, got[i], exp_b[i]);
         end
      end
      nvec++;
      if (len_err !== exp_err) begin
         nerr++;
         $display("FAIL %s len_err: got %b required %b", nm, len_err, exp_err);
      end
      nvec++;
      if (fd_cyc.size() != exp_fl) begin
         nerr++;
         $display("FAIL %s flush_done_count: got %0d required %0d", nm, fd_cyc.size(), exp_fl);
      end
`ifdef HUFF_PACK_STATS_EN
      nvec++;
      if (bits_total !== 32'(exp_bits)) begin
         nerr++;
         $display("FAIL %s bits_total: got %0d required %0d", nm, bits_total, exp_bits);
      end
      nvec++;
      if (bytes_total !== 32'(exp_b.size())) begin
         nerr++;
         $display("FAIL %s bytes_total: got %0d required %0d", nm, bytes_total, exp_b.size());
      end
`endif
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      byte_ready = 1'b1;
      fq.delete();
      fq.push_back(w(8, 27'hFF));
      fifo_refresh();
      #2;
      nvec++;
      if ({byte_valid, fifo_rd, len_err, flush_done, byte_out} !== 12'h000) begin
         nerr++;
         $display("FAIL reset_state: got v=%b rd=%b err=%b fd=%b out=%h required all 0",
                  byte_valid, fifo_rd, len_err, flush_done, byte_out);
      end
      do_reset();
      byte_ready = 1'b1;
      push(w(30, 27'h1));
      push(w(3, 27'b101));
      push(w(2, 27'b00));
      repeat (4) @(negedge clk);
      #2;
      nvec++;
      if (len_err !== 1'b1 || byte_valid !== 1'b0) begin
         nerr++;
         $display("FAIL pre_reset_state: got err=%b v=%b required err=1 v=0", len_err, byte_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({byte_valid, fifo_rd, len_err, flush_done} !== 4'b0000) begin
         nerr++;
         $display("FAIL async_reset: got v=%b rd=%b err=%b fd=%b required 0000",
                  byte_valid, fifo_rd, len_err, flush_done);
      end
      @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      push(w(8, 27'h3C));
      drain(0, "reset_new");
      check_stream("reset_new");
   endtask

   task automatic test_pack();
      do_reset();
      byte_ready = 1'b1;
      push(w(3, 27'b101));
      push(w(5, 27'b10011));
      drain(0, "pack");
      check_stream("pack");
      nvec++;
      if (byte_valid !== 1'b0) begin
         nerr++;
         $display("FAIL pack_idle_valid: got %b required 0", byte_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      byte_ready = 1'b1;
      push(w(12, 27'hABC));
      push(w(0, 27'h0));
      drain(0, "flush");
      check_stream("flush");
      nvec++;
      if (fd_cyc.size() != 1 || hs_cyc.size() == 0 || fd_cyc[0] != hs_cyc[hs_cyc.size()-1] + 1) begin
         nerr++;
         $display("FAIL flush_done_timing: got fd=%0d required hs+1=%0d",
                  fd_cyc.size() ? fd_cyc[0] : -1,
                  hs_cyc.size() ? hs_cyc[hs_cyc.size()-1] + 1 : -1);
      end
      do_reset();
      byte_ready = 1'b1;
      push(w(0, 27'h0));
      drain(0, "flush_empty");
      check_stream("flush_empty");
      nvec++;
      if (fd_cyc.size() != 1 || fl_pop_cyc.size() != 1 || fd_cyc[0] != fl_pop_cyc[0] + 2) begin
         nerr++;
         $display("FAIL flush_empty_timing: got fd=%0d required pop+2=%0d",
                  fd_cyc.size() ? fd_cyc[0] : -1,
                  fl_pop_cyc.size() ? fl_pop_cyc[0] + 2 : -1);
      end
   endtask

   task automatic test_stall();
      do_reset();
      byte_ready = 1'b0;
      push(w(16, 27'h1234));
      push(w(8, 27'h77));
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #2;
         nvec++;
         if (byte_valid !== 1'b1 || byte_out !== 8'h12 || fifo_rd !== 1'b0) begin
            nerr++;
            $display("FAIL stall[%0d]: got v=%b out=%h rd=%b required v=1 out=12 rd=0",
                     i, byte_valid, byte_out, fifo_rd);
         end
      end
      drain(0, "stall");
      check_stream("stall");
      nvec++;
      if (hs_cyc.size() < 2 || hs_cyc[1] != hs_cyc[0] + 1) begin
         nerr++;
         $display("FAIL stall_back_to_back: got %0d handshakes required consecutive", hs_cyc.size());
      end
   endtask

   task automatic test_len_err();
      do_reset();
      byte_ready = 1'b1;
      push(w(30, 27'($urandom)));
      push(w(8, 27'h5A));
      drain(0, "len_err");
      check_stream("len_err");
      repeat (5) @(negedge clk);
      #2;
      nvec++;
      if (len_err !== 1'b1) begin
         nerr++;
         $display("FAIL len_err_sticky: got %b required 1", len_err);
      end
   endtask

   task automatic test_max();
      do_reset();
      byte_ready = 1'b1;
      push(w(27, 27'h7FFFFFF));
      push(w(5, 27'h0));
      drain(0, "max_len");
      check_stream("max_len");
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int nw = $urandom_range(20, 40);
         int k = 0;
         do_reset();
         while (k < nw) begin
            @(negedge clk);
            byte_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
               int sel = $urandom_range(0, 19);
               int L;
               if (sel < 2)
                  L = 0;
               else if (sel < 3)
                  L = $urandom_range(28, 31);
               else
                  L = $urandom_range(1, 27);
               push(w(L, 27'($urandom)));
               k++;
            end
         end
         push(w(0, 27'($urandom)));
         drain(1, "random");
         check_stream("random");
      end
   endtask

   initial begin
      fifo_refresh();
      test_reset();
      test_pack();
      test_flush();
      test_stall();
      test_len_err();
      test_max();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
